// File: rtl/LLC_defs.sv
// Shared last-level-cache bus definitions plus the snoop responder's state encoding.
package LLC_defs;
   typedef enum logic [2:0] {
      NOBUSOP    = 3'd0,
      READ       = 3'd1,
      WRITE      = 3'd2,
      INVALIDATE = 3'd3,
      RWIM       = 3'd4
   } busOperation;

   typedef enum logic [1:0] {
      HIT   = 2'b00,
      HITM  = 2'b01,
      NOHIT = 2'b10
   } snoopResults;

   localparam int LINE_OFFSET_BITS = 6;

   typedef enum logic [1:0] {
      SNP_IDLE    = 2'd0,
      SNP_LOOKUP  = 2'd1,
      SNP_WB      = 2'd2,
      SNP_RESPOND = 2'd3
   } snoop_state_e;
endpackage

// File: rtl/snoop_dir.sv
// Direct-mapped remote-line directory: flop array with one combinational read port,
// one write port and a single-cycle synchronous clear of all valid bits.
module snoop_dir #(
   parameter int ENTRIES = 256,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = 26 - IDX_W
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_valid_o,
   output logic [TAG_W-1:0] rd_tag_o,
   output logic             rd_dirty_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_valid_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  logic             wr_dirty_i
);
   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q   [ENTRIES];
   logic               dirty_q [ENTRIES];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end
   end

   // Tag and dirty carry no meaning without valid, so they are never cleared.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]   <= wr_tag_i;
         dirty_q[wr_idx_i] <= wr_dirty_i;
      end
   end
endmodule

// File: rtl/snoop_responder.sv
// Models the other processors' LLCs on the shared bus: answers one bus operation at a
// time with HIT/HITM/NOHIT and applies the MESI snooper's state change to the remote copy.
module snoop_responder
   import LLC_defs::*;
#(
   parameter int DIR_ENTRIES = 256,
   parameter int HITM_DELAY  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  busOperation req_op,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output snoopResults rsp_result,
   input  logic        pre_we,
   input  logic [31:0] pre_addr,
   input  logic        pre_dirty,
   output logic        proto_err,
   output logic [31:0] cnt_hit,
   output logic [31:0] cnt_hitm,
   output logic [31:0] cnt_nohit
);
   localparam int IDX_W  = $clog2(DIR_ENTRIES);
   localparam int LINE_W = 32 - LINE_OFFSET_BITS;
   localparam int TAG_W  = LINE_W - IDX_W;

   localparam logic [1:0] S_IDLE    = 2'(SNP_IDLE);
   localparam logic [1:0] S_LOOKUP  = 2'(SNP_LOOKUP);
   localparam logic [1:0] S_WB      = 2'(SNP_WB);
   localparam logic [1:0] S_RESPOND = 2'(SNP_RESPOND);

   logic [1:0]        state_q, state_d;
   busOperation       op_q, op_d;
   logic [LINE_W-1:0] addr_q, addr_d;
   logic [3:0]        wbcnt_q, wbcnt_d;
   snoopResults       result_q, result_d;
   logic              err_q, err_d;
   logic [31:0]       hit_q, hit_d, hitm_q, hitm_d, nohit_q, nohit_d;

   logic             rd_valid, rd_dirty, match;
   logic [TAG_W-1:0] rd_tag;
   logic             dir_we, dir_wvalid, dir_wdirty;
   logic [IDX_W-1:0] dir_widx;
   logic [TAG_W-1:0] dir_wtag;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{req_addr[LINE_OFFSET_BITS-1:0], pre_addr[LINE_OFFSET_BITS-1:0]};

   snoop_dir #(.ENTRIES(DIR_ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_dir (
      .clk_i      (clk),
      .clr_i      (!rst_n),
      .rd_idx_i   (addr_q[IDX_W-1:0]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_dirty_o (rd_dirty),
      .wr_en_i    (dir_we),
      .wr_idx_i   (dir_widx),
      .wr_valid_i (dir_wvalid),
      .wr_tag_i   (dir_wtag),
      .wr_dirty_i (dir_wdirty)
   );

   assign match      = rd_valid && (rd_tag == addr_q[LINE_W-1:IDX_W]);
   assign req_ready  = rst_n && (state_q == S_IDLE) && !pre_we;
   assign rsp_valid  = (state_q == S_RESPOND);
   assign rsp_result = result_q;
   assign proto_err  = err_q;
   assign cnt_hit    = hit_q;
   assign cnt_hitm   = hitm_q;
   assign cnt_nohit  = nohit_q;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wbcnt_d    = wbcnt_q;
      result_d   = result_q;
      err_d      = err_q;
      hit_d      = hit_q;
      hitm_d     = hitm_q;
      nohit_d    = nohit_q;
      dir_we     = 1'b0;
      dir_widx   = pre_addr[LINE_OFFSET_BITS +: IDX_W];
      dir_wtag   = pre_addr[31 -: TAG_W];
      dir_wvalid = 1'b1;
      dir_wdirty = pre_dirty;
      case (state_q)
         S_IDLE: begin
            if (pre_we) begin
               dir_we = 1'b1;
            end else if (req_valid && req_op != NOBUSOP) begin
               op_d    = req_op;
               addr_d  = req_addr[31:LINE_OFFSET_BITS];
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            dir_widx   = addr_q[IDX_W-1:0];
            dir_wtag   = addr_q[LINE_W-1:IDX_W];
            dir_wdirty = rd_dirty;
            result_d   = NOHIT;
            case (op_q)
               READ: begin
                  // Remote M->S: the writeback leaves the remote copy clean.
                  if (match && rd_dirty) begin
                     result_d   = HITM;
                     dir_we     = 1'b1;
                     dir_wdirty = 1'b0;
                  end else if (match) begin
                     result_d = HIT;
                  end
               end
               WRITE: begin
                  if (match && rd_dirty) err_d = 1'b1;
               end
               INVALIDATE: begin
                  if (match) begin
                     result_d   = HIT;
                     dir_we     = 1'b1;
                     dir_wvalid = 1'b0;
                     if (rd_dirty) err_d = 1'b1;
                  end
               end
               RWIM: begin
                  if (match) begin
                     result_d   = rd_dirty ? HITM : HIT;
                     dir_we     = 1'b1;
                     dir_wvalid = 1'b0;
                  end
               end
               default: result_d = NOHIT;
            endcase
            wbcnt_d = 4'(HITM_DELAY);
            state_d = (result_d == HITM && HITM_DELAY > 0) ? S_WB : S_RESPOND;
         end
         S_WB: begin
            if (wbcnt_q == 4'd1) state_d = S_RESPOND;
            else                 wbcnt_d = wbcnt_q - 4'd1;
         end
         default: begin
            if (rsp_ready) begin
               case (result_q)
                  HIT:     hit_d   = hit_q + 32'd1;
                  HITM:    hitm_d  = hitm_q + 32'd1;
                  default: nohit_d = nohit_q + 32'd1;
               endcase
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= NOHIT;
         err_q    <= 1'b0;
         hit_q    <= '0;
         hitm_q   <= '0;
         nohit_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         err_q    <= err_d;
         hit_q    <= hit_d;
         hitm_q   <= hitm_d;
         nohit_q  <= nohit_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wbcnt_q <= wbcnt_d;
   end

`ifdef DEBUG
   always_ff @(posedge clk) begin
      if (rst_n && state_q == S_RESPOND && rsp_ready)
         $display("snoop_responder: %s addr=%h result=%s", op_q.name(),
                  {addr_q, {LINE_OFFSET_BITS{1'b0}}}, result_q.name());
   end
`endif
endmodule

// File: tb/tb_snoop_responder.sv
// Directed and random bench for snoop_responder against a table-driven MESI snooper model.
module tb_snoop_responder;
   import LLC_defs::*;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   busOperation req_op;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   snoopResults rsp_result;
   logic        pre_we;
   logic [31:0] pre_addr;
   logic        pre_dirty;
   logic        proto_err;
   logic [31:0] cnt_hit, cnt_hitm, cnt_nohit;

   always #5 clk = ~clk;

   snoop_responder #(.DIR_ENTRIES(256), .HITM_DELAY(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .pre_we(pre_we), .pre_addr(pre_addr), .pre_dirty(pre_dirty),
      .proto_err(proto_err),
      .cnt_hit(cnt_hit), .cnt_hitm(cnt_hitm), .cnt_nohit(cnt_nohit)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: remote copies keyed by directory slot, holding full line address.
   bit          m_valid [256];
   logic [25:0] m_line  [256];
   bit          m_dirty [256];
   bit          m_err;
   int unsigned m_hit, m_hitm, m_nohit;

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
      m_err = 1'b0; m_hit = 0; m_hitm = 0; m_nohit = 0;
   endtask

   task automatic model_preload(input logic [31:0] a, input bit dirty);
      m_valid[a[13:6]] = 1'b1;
      m_line[a[13:6]]  = a[31:6];
      m_dirty[a[13:6]] = dirty;
   endtask

   function automatic snoopResults predict(input busOperation op, input logic [31:0] a);
      int  i     = int'(a[13:6]);
      bit  hit   = m_valid[i] && (m_line[i] == a[31:6]);
      bit  dirty = m_dirty[i];
      snoopResults r = NOHIT;
      if (op == READ && hit) begin
         r = dirty ? HITM : HIT;
         m_dirty[i] = 1'b0;
      end else if (op == WRITE) begin
         if (hit && dirty) m_err = 1'b1;
      end else if (op == INVALIDATE && hit) begin
         r = HIT;
         if (dirty) m_err = 1'b1;
         m_valid[i] = 1'b0;
      end else if (op == RWIM && hit) begin
         r = dirty ? HITM : HIT;
         m_valid[i] = 1'b0;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("cnt_hit", cnt_hit, m_hit);
      chk("cnt_hitm", cnt_hitm, m_hitm);
      chk("cnt_nohit", cnt_nohit, m_nohit);
      chk("proto_err", proto_err, m_err);
   endtask

   task automatic preload(input logic [31:0] a, input bit dirty);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_dirty = dirty;
      model_preload(a, dirty);
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic do_req(input busOperation op, input logic [31:0] a, input int hold);
      snoopResults exp_r;
      int bud, lat;
      @(negedge clk);
      pre_we = 1'b0;
      req_valid = 1'b1; req_op = op; req_addr = a;
      #1;
      bud = 0;
      while (!req_ready && bud < 20) begin @(negedge clk); #1; bud++; end
      if (!req_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      exp_r = predict(op, a);
      @(negedge clk);
      req_valid = 1'b0; req_op = NOBUSOP;
      lat = 1;
      while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      chk("latency", lat, (exp_r == HITM) ? 2 + D : 2);
      chk("result", rsp_result, exp_r);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("hold_stable", {rsp_valid, rsp_result}, {1'b1, exp_r});
      end
      rsp_ready = 1'b1;
      case (exp_r)
         HIT:     m_hit++;
         HITM:    m_hitm++;
         default: m_nohit++;
      endcase
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 1'b0);
      chk("ready_after", req_ready, 1'b1);
      check_state();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      rst_n = 1'b0; req_valid = 1'b0; req_op = NOBUSOP; req_addr = '0;
      rsp_ready = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_dirty = 1'b0;
      model_reset();

      // Reset values
      repeat (2) @(negedge clk);
      chk("reset_ready", req_ready, 1'b0);
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_result", rsp_result, NOHIT);
      check_state();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_post_reset", req_ready, 1'b1);

      // Empty directory, dirty read with writeback delay, then clean re-read
      do_req(READ, 32'h0000_1040, 0);
      preload(32'h0000_1040, 1'b1);
      do_req(READ, 32'h0000_1040, 0);
      do_req(READ, 32'h0000_1040, 0);

      // RWIM invalidates a clean copy
      preload(32'h0000_2080, 1'b0);
      do_req(RWIM, 32'h0000_2080, 0);
      do_req(READ, 32'h0000_2080, 0);

      // Writeback hitting a remote modified copy is illegal and sticky
      preload(32'h0000_3000, 1'b1);
      do_req(WRITE, 32'h0000_3000, 0);
      do_req(READ, 32'h0000_3000, 1);
      do_req(INVALIDATE, 32'h0000_1040, 0);

      // Preload and request in the same cycle: preload wins, request sees it
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 32'h0000_4040; pre_dirty = 1'b0;
      req_valid = 1'b1; req_op = READ; req_addr = 32'h0000_4040;
      #1;
      chk("ready_blocked_by_preload", req_ready, 1'b0);
      model_preload(32'h0000_4040, 1'b0);
      do_req(READ, 32'h0000_4040, 5);

      // Reset while a HITM is waiting out its writeback delay
      preload(32'h0000_5000, 1'b1);
      @(negedge clk);
      req_valid = 1'b1; req_op = READ; req_addr = 32'h0000_5000;
      @(negedge clk);
      req_valid = 1'b0; req_op = NOBUSOP;
      repeat (2) @(negedge clk);
      chk("in_wb_no_rsp", rsp_valid, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_ready", req_ready, 1'b0);
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("dropped_no_rsp", rsp_valid, 1'b0);
      end
      check_state();
      do_req(READ, 32'h0000_5000, 0);
      do_req(READ, 32'h0000_4040, 0);

      // Random traffic over a few slots with two aliasing tags each
      for (int n = 0; n < 80; n++) begin
         a = ($urandom_range(0, 1) << 14) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
         if ($urandom_range(0, 2) == 0) preload(a, 1'($urandom_range(0, 1)));
         a = ($urandom_range(0, 1) << 14) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
         do_req(busOperation'($urandom_range(1, 4)), a, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/snoop_responder.md
# snoop_responder

Bus-side responder that models the last-level caches of the other processors on the shared bus. It accepts one bus operation (READ, WRITE, INVALIDATE, RWIM) at a time from our LLC and looks the line up in a small remote-line directory. It returns HIT, HITM or NOHIT and updates the remote copy's state the way a MESI snooper would. It closes the loop the LLC's bus interface currently leaves open: our LLC initiates, this block responds.

## Interface
- `DIR_ENTRIES`, default 256. Direct-mapped remote directory depth; power of two.
- `HITM_DELAY`, default 4. Extra cycles charged for a modified-line writeback before a HITM response; range 0..15.
- `clk` in 1: sole clock; all state changes on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: bus operation request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_op` in busOperation: READ, WRITE, INVALIDATE, RWIM. NOBUSOP is never accepted.
- `req_addr` in 32: byte address. Bits [5:0] are the line offset and are ignored.
- `rsp_valid` out 1: snoop result present.
- `rsp_ready` in 1: LLC consumes the result.
- `rsp_result` out snoopResults: NOHIT, HIT, HITM.
- `pre_we` in 1: preload/overwrite one directory entry; models remote-processor activity.
- `pre_addr` in 32: line to install.
- `pre_dirty` in 1: install as modified (1) or clean (0).
- `proto_err` out 1: sticky; set on an illegal request.
- `cnt_hit`, `cnt_hitm`, `cnt_nohit` out 32 each: response counters.

## Operation
- Directory addressing: index is `addr[6 +: log2(DIR_ENTRIES)]`; tag is the remaining upper bits.
- Each directory entry holds `valid`, `tag` and `dirty`. A match means valid and tag equal.
- FSM states: IDLE, LOOKUP, WB, RESPOND.
- IDLE, when `req_valid && req_ready`:
  - Latch `req_op` and `req_addr`.
  - Go to LOOKUP.
- LOOKUP: compute the result and the directory update from the latched request.
  - READ: match and dirty gives HITM, and the entry is marked clean (remote goes M->S). Match and clean gives HIT, no change. No match gives NOHIT.
  - WRITE (LLC writeback): always NOHIT, no change. A match with dirty=1 is illegal: set `proto_err`.
  - INVALIDATE: match and clean gives HIT, and the entry is invalidated. Match and dirty gives HIT, the entry is invalidated and `proto_err` is set. No match gives NOHIT.
  - RWIM: match and dirty gives HITM. Match and clean gives HIT. Either match invalidates the entry. No match gives NOHIT.
  - Next state is WB if the result is HITM and `HITM_DELAY` is greater than 0; otherwise RESPOND.
- Directory write: happens at the end of LOOKUP.
- WB: down-counter loaded with `HITM_DELAY`; moves to RESPOND when the counter reaches 1.
- RESPOND:
  - `rsp_valid`=1; `rsp_result` stays stable until `rsp_ready`.
  - On handshake, increment the matching counter and go to IDLE.
- Preload:
  - Honoured only in IDLE. It writes valid=1, the tag and `pre_dirty` to the entry, overwriting whatever was there.
  - `pre_we` outside IDLE is ignored.
- Counters wrap modulo 2^32.
- Under `DEBUG`, the block displays the operation, address and result at each response handshake.

## Timing
- `req_ready` = (state==IDLE) && !`pre_we`. A preload in the same cycle as a request wins; the request waits.
- Latency from acceptance edge to first `rsp_valid` cycle:
  - 2 cycles for HIT/NOHIT.
  - 2+`HITM_DELAY` cycles for HITM.
- Back-to-back throughput: one request per 3 cycles minimum, with `rsp_ready` held high.
- `rsp_valid` is deasserted the cycle after the handshake. Another request can be accepted in that same cycle (IDLE).
- A LOOKUP sees the directory as left by the previous request's LOOKUP write or by the previous preload.
- Reset values, from the first edge with `rst_n`=0:
  - state=IDLE.
  - `req_ready`=1 after reset releases; 0 during reset.
  - `rsp_valid`=0, `rsp_result`=NOHIT.
  - `proto_err`=0.
  - All counters = 0.
  - All directory valid bits = 0.
- Reset mid-transaction: the in-flight request is dropped, with no response and no counter change.
- Directory clear on reset is completed in one cycle (flop array, not RAM).

## Structure
- In `LLC_defs`: `busOperation` and `snoopResults`, reused as-is. Add `LINE_OFFSET_BITS`=6 and the `snoop_state_e` enum.
- One sub-module: `snoop_dir`, the direct-mapped valid/tag/dirty array. It has:
  - One combinational read port.
  - One write port, muxed between the LOOKUP update and the preload.
  - A synchronous clear.

## Test plan
- Reset, then READ 0x0000_1040 on an empty directory -> NOHIT; `rsp_valid` 2 cycles after acceptance; `cnt_nohit`=1.
- Preload 0x0000_1040 dirty, then READ 0x0000_1040 -> HITM after 2+4 cycles. A second READ -> HIT (entry now clean).
- Preload 0x0000_2080 clean, then RWIM 0x0000_2080 -> HIT. A following READ -> NOHIT.
- Preload 0x0000_3000 dirty, then WRITE 0x0000_3000 -> NOHIT with `proto_err`=1 and staying 1.
- Same-cycle `pre_we` and `req_valid` in IDLE -> `req_ready`=0, preload applied, request accepted the next cycle and sees the preloaded entry. Hold `rsp_ready`=0 for 5 cycles -> `rsp_result` stable throughout.
- Assert `rst_n`=0 during WB of a HITM -> no response, counters 0, directory empty; next READ of the same line -> NOHIT.
